fetch_queue: RTL

Instruction-fetch front end that sits directly upstream of the decode/control stage.
- Owns the fetch PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- A taken branch or jump redirects fetch and flushes all buffered and in-flight instructions.

---
 rtl/riscv_micro_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_queue.sv | 93 +++++++++
 3 files changed

// File: rtl/riscv_micro_pkg.sv
// Shared fetch/decode constants and the fetch-entry type.
package riscv_micro_pkg;

  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam int ENTRY_PC_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [INST_W-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO for fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [W-1:0]             head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign push_en    = push && !flush;
  assign pop_en     = pop && head_valid && !flush;
  assign head_valid = (count != '0);
  // Empty FIFO presents zeros rather than stale storage.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns fetch PC, credit-limited imem reads, redirect flush.
// Optional FETCH_STALL_COUNT_EN adds a saturating decode-starvation counter (stall_count).
module fetch_queue
  import riscv_micro_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [PC_W-1:0]   inst_pc,
`ifdef FETCH_STALL_COUNT_EN
  output logic [31:0]       stall_count,
`endif
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + INST_W;

  // Handshake: decode takes the head entry on any cycle with inst_valid && inst_ready.
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            inflight_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            pop;
  logic            push;
  logic [EW-1:0]   head_data;

  assign pop = inst_valid && inst_ready;
  // A return in the redirect cycle belongs to the squashed path.
  assign push = inflight_q && !redirect;

  // Slots committed = entries that survive this cycle plus the read already in flight.
  assign credit_used = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + PC_W'(PC_INC);
        req_pc_q   <= fetch_pc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  ({req_pc_q, imem_rdata}),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid),
    .head_data  (head_data)
  );

  assign inst_pc   = head_data[EW-1:INST_W];
  assign inst_data = head_data[INST_W-1:0];

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (inst_ready && !inst_valid && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
